quad_pos_ctrl: RTL and testbench
================================

Name: quad_pos_ctrl

Overview:
Quadrature position controller for the A/B direction-detection path. It synchronises and glitch-filters raw i_A/i_B, then decodes full 4x quadrature steps with a registered phase state machine. It maintains a wrap-around position counter, a direction flag and a sticky illegal-transition error. Host-side controls (enable, clear, preload, error clear) configure the counter; the block feeds motor and position logic downstream.

Parameters:
CNT_W, 16, position counter width (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 4, consecutive stable cycles required before a filtered level changes (>=1)

Ports:
i_Clk  in  1  system clock, rising edge
i_Rst  in  1  reset, asynchronous, active-high
i_A  in  1  raw quadrature channel A, asynchronous to i_Clk
i_B  in  1  raw quadrature channel B, asynchronous to i_Clk
i_En  in  1  count enable
i_Clr  in  1  synchronous clear of position to 0
i_Load  in  1  synchronous preload strobe
i_LoadVal  in  CNT_W  preload value
i_ErrClr  in  1  clears o_Err
o_Pos  out  CNT_W  position, unsigned modulo 2^CNT_W
o_Forw  out  1  one-cycle pulse per valid forward step
o_Back  out  1  one-cycle pulse per valid backward step
o_UD  out  1  last valid direction: 1 = forward, 0 = backward
o_Wrap  out  1  one-cycle pulse when o_Pos wraps (max->0 or 0->max)
o_Err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (async assert, sync release): sync flops, filtered levels and phase state = 00. Filter counters = 0. o_Pos = 0. o_Forw, o_Back, o_Wrap, o_Err, o_UD = 0.
- Sync: SYNC_STAGES-flop chain per channel; no logic between stages.
- Filter, per channel: when the synced level differs from the filtered level, the run counter increments. The filtered level takes the new value on the cycle the counter reaches FILT_LEN, and the counter returns to 0. If the synced level equals the filtered level, the counter returns to 0, so a glitch shorter than FILT_LEN cycles is discarded.
- Phase FSM: the state is the registered {A_f,B_f}.
  - Forward order: 00->10->11->01->00 (A leads B).
  - Backward order: 00->01->11->10->00.
  - An unchanged phase is idle.
  - An illegal transition (both channels change in the same cycle: 00<->11, 10<->01) sets o_Err. It produces no step and no pulse, and the state resyncs to the new phase.
- Latency: a clean level change on i_A held stable produces o_Forw exactly SYNC_STAGES+FILT_LEN+1 cycles after the first i_Clk edge that samples it. This is 7 cycles at defaults.
- Step outputs are registered. o_Forw/o_Back last 1 cycle and are never high together.
  - A valid step with i_En=1: o_Pos +/-1 modulo 2^CNT_W.
  - o_UD is set to 1 on a forward step and 0 on a backward step; otherwise it holds.
  - o_Wrap pulses in the same cycle o_Pos goes 2^CNT_W-1 -> 0 (forward) or 0 -> 2^CNT_W-1 (backward).
- i_En=0: the filter and phase FSM keep tracking, so there is no false step on re-enable. There are no pulses, no count, no o_UD update and no o_Err set.
- Counter priority in one cycle: i_Clr > i_Load > step.
  - Clr or Load in the same cycle as a step: the step is dropped (no pulse, no o_Wrap). o_UD still updates.
  - Load writes i_LoadVal next cycle. Clr writes 0.
- o_Err priority: an illegal transition in the same cycle as i_ErrClr leaves o_Err = 1 (set wins).
- Reset mid-sequence: all state is cleared immediately. After release, the first filtered phase change is decoded relative to 00. If it is 00->11, o_Err is set.

Decomposition:
- Shared package quad_pkg:
  - phase encoding constants PH_00, PH_10, PH_11, PH_01
  - functions is_fwd(prev,cur), is_back(prev,cur), is_illegal(prev,cur)
- Sub-module quad_chan_filter (synchroniser + run-length filter, params SYNC_STAGES/FILT_LEN), instantiated once per channel.
- The top level holds the phase FSM, counter, flags and control priority.

Test Plan:
- From reset, i_En=1, drive A/B through 10,11,01,00, each held 10 cycles: o_Forw pulses 4 times, o_Pos = 4, o_UD = 1. The first pulse comes 7 cycles after the A edge.
- From o_Pos = 0, one backward step (01): o_Pos = 16'hFFFF, o_Wrap and o_Back pulse the same cycle, o_UD = 0. A forward step then gives o_Pos = 0 with o_Wrap pulsed.
- Pulse i_A high for 3 cycles (FILT_LEN=4): no o_Forw, o_Pos unchanged, no o_Err. Repeat with 4 cycles: one step is counted.
- Drive A and B 00->11 simultaneously: o_Err = 1, no pulses, o_Pos unchanged. Then 11->01 counts forward. i_ErrClr clears o_Err next cycle.
- i_LoadVal = 16'h1234 with i_Load and a forward step landing in the same cycle: o_Pos = 16'h1234, no o_Forw. i_Clr together with i_Load gives o_Pos = 0.
- Assert i_Rst mid-phase (state 11, o_Pos = 7): outputs are zero asynchronously. After release, with A/B held at 11, o_Err = 1 and o_Pos = 0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared phase encoding and transition classification for the quadrature decoder.
// Phases are {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == PH_00) && (cur == PH_10)) ||
           ((prev == PH_10) && (cur == PH_11)) ||
           ((prev == PH_11) && (cur == PH_01)) ||
           ((prev == PH_01) && (cur == PH_00));
  endfunction

  function automatic logic is_back(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == PH_00) && (cur == PH_01)) ||
           ((prev == PH_01) && (cur == PH_11)) ||
           ((prev == PH_11) && (cur == PH_10)) ||
           ((prev == PH_10) && (cur == PH_00));
  endfunction

  // Both channels moving in one cycle cannot be attributed to a direction.
  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return (prev ^ cur) == 2'b11;
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One quadrature channel: plain flop synchroniser followed by a run-length glitch filter.
// The filtered level only follows the synced level after FILT_LEN consecutive differing cycles.
module quad_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter hitting FILT_LEN and the level flip happen on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      filt    <= 1'b0;
    end else if (synced != filt) begin
      if (run_cnt == CW'(FILT_LEN - 1)) begin
        filt    <= synced;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: rtl/quad_pos_ctrl.sv
// Quadrature position controller: filtered A/B phase tracking, wrap-around position
// counter, direction flag and sticky illegal-transition error.
import quad_pkg::*;

module quad_pos_ctrl #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_A,
  input  logic             i_B,
  input  logic             i_En,
  input  logic             i_Clr,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_LoadVal,
  input  logic             i_ErrClr,
  output logic [CNT_W-1:0] o_Pos,
  output logic             o_Forw,
  output logic             o_Back,
  output logic             o_UD,
  output logic             o_Wrap,
  output logic             o_Err
);

  localparam logic [CNT_W-1:0] POS_MAX = '1;

  logic       a_filt;
  logic       b_filt;
  logic [1:0] phase_q;
  logic [1:0] phase_cur;
  logic       step_fwd;
  logic       step_back;
  logic       step_ill;
  logic       ctrl_hit;

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk (i_Clk),
    .rst (i_Rst),
    .raw (i_A),
    .filt(a_filt)
  );

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk (i_Clk),
    .rst (i_Rst),
    .raw (i_B),
    .filt(b_filt)
  );

  assign phase_cur = {a_filt, b_filt};
  assign step_fwd  = i_En & is_fwd(phase_q, phase_cur);
  assign step_back = i_En & is_back(phase_q, phase_cur);
  assign step_ill  = i_En & is_illegal(phase_q, phase_cur);
  assign ctrl_hit  = i_Clr | i_Load;

  // Phase keeps tracking even when disabled so re-enable never sees a stale step.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      phase_q <= PH_00;
      o_UD    <= 1'b0;
      o_Err   <= 1'b0;
    end else begin
      phase_q <= phase_cur;
      if (step_fwd) begin
        o_UD <= 1'b1;
      end else if (step_back) begin
        o_UD <= 1'b0;
      end
      if (step_ill) begin
        o_Err <= 1'b1;
      end else if (i_ErrClr) begin
        o_Err <= 1'b0;
      end
    end
  end

  // Clear and preload override a coincident step, which then produces no pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Pos  <= '0;
      o_Forw <= 1'b0;
      o_Back <= 1'b0;
      o_Wrap <= 1'b0;
    end else begin
      o_Forw <= step_fwd & ~ctrl_hit;
      o_Back <= step_back & ~ctrl_hit;
      o_Wrap <= ~ctrl_hit & ((step_fwd & (o_Pos == POS_MAX)) |
                             (step_back & (o_Pos == '0)));
      if (i_Clr) begin
        o_Pos <= '0;
      end else if (i_Load) begin
        o_Pos <= i_LoadVal;
      end else if (step_fwd) begin
        o_Pos <= o_Pos + CNT_W'(1);
      end else if (step_back) begin
        o_Pos <= o_Pos - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_pos_ctrl.sv
// Self-checking bench for quad_pos_ctrl: directed and randomized phase walks
// compared against a step-level model of the quadrature rules.
`timescale 1ns/1ps

module tb_quad_pos_ctrl;

  localparam int CNT_W   = 16;
  localparam int POS_MOD = 1 << CNT_W;
  localparam int LAT     = 7;

  logic             virtualClk = 1'b0;
  logic             rst;
  logic             a, b, en, clr, load, err_clr;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] o_pos;
  logic             o_forw, o_back, o_ud, o_wrap, o_err;

  int compare_cnt = 0;
  int fail_cnt    = 0;

  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_pos;
  int m_idx;
  bit m_ud;
  bit m_err;

  always #5 virtualClk = ~virtualClk;

  quad_pos_ctrl dut (
    .i_Clk    (virtualClk),
    .i_Rst    (rst),
    .i_A      (a),
    .i_B      (b),
    .i_En     (en),
    .i_Clr    (clr),
    .i_Load   (load),
    .i_LoadVal(load_val),
    .i_ErrClr (err_clr),
    .o_Pos    (o_pos),
    .o_Forw   (o_forw),
    .o_Back   (o_back),
    .o_UD     (o_ud),
    .o_Wrap   (o_wrap),
    .o_Err    (o_err)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [1:0] code);
    for (int i = 0; i < 4; i++) if (seq[i] == code) return i;
    return 0;
  endfunction

  // Position of the new phase in the forward cycle decides the step kind.
  task automatic model_step(input int new_idx, input bit step_en, input bit dropped,
                            output int fw, output int bk, output int wr);
    int kind;
    kind = (new_idx - m_idx + 4) % 4;
    fw = 0; bk = 0; wr = 0;
    if (step_en) begin
      if (kind == 1) begin
        m_ud = 1'b1;
        if (!dropped) begin
          fw = 1;
          if (m_pos == POS_MOD - 1) wr = 1;
          m_pos = (m_pos + 1) % POS_MOD;
        end
      end else if (kind == 3) begin
        m_ud = 1'b0;
        if (!dropped) begin
          bk = 1;
          if (m_pos == 0) wr = 1;
          m_pos = (m_pos + POS_MOD - 1) % POS_MOD;
        end
      end else if (kind == 2) begin
        m_err = 1'b1;
      end
    end
    m_idx = new_idx;
  endtask

  task automatic model_ctl(input bit do_clr, input bit do_load, input int val, input bit do_errclr);
    if (do_clr) m_pos = 0;
    else if (do_load) m_pos = val % POS_MOD;
    if (do_errclr) m_err = 1'b0;
  endtask

  task automatic apply_stimulus(input int new_idx, input bit step_en, input bit do_clr,
                                input bit do_load, input int val, input bit do_errclr,
                                input int ctl_at, input int hold, input string tag);
    int exp_fw, exp_bk, exp_wr;
    int got_fw, got_bk, got_wr, overlap, first_pulse;
    bit has_ctl, dropped;
    got_fw = 0; got_bk = 0; got_wr = 0; overlap = 0; first_pulse = 0;
    has_ctl = do_clr | do_load | do_errclr;
    dropped = (ctl_at == LAT) && (do_clr || do_load);
    if (has_ctl && ctl_at <= LAT) model_ctl(do_clr, do_load, val, do_errclr);
    model_step(new_idx, step_en, dropped, exp_fw, exp_bk, exp_wr);
    if (has_ctl && ctl_at > LAT) model_ctl(do_clr, do_load, val, do_errclr);
    {a, b} = seq[new_idx];
    en = step_en;
    for (int c = 1; c <= hold; c++) begin
      if (has_ctl && c == ctl_at) begin
        clr = do_clr; load = do_load; load_val = CNT_W'(val); err_clr = do_errclr;
      end
      @(posedge virtualClk);
      @(negedge virtualClk);
      clr = 1'b0; load = 1'b0; err_clr = 1'b0;
      if (o_forw) got_fw++;
      if (o_back) got_bk++;
      if (o_wrap) got_wr++;
      if (o_forw && o_back) overlap++;
      if ((o_forw || o_back) && first_pulse == 0) first_pulse = c;
    end
    check_output({tag, " forw"}, got_fw, exp_fw);
    check_output({tag, " back"}, got_bk, exp_bk);
    check_output({tag, " wrap"}, got_wr, exp_wr);
    check_output({tag, " overlap"}, overlap, 0);
    check_output({tag, " pos"}, o_pos, m_pos);
    check_output({tag, " ud"}, o_ud, m_ud);
    check_output({tag, " err"}, o_err, m_err);
    if (exp_fw + exp_bk > 0) check_output({tag, " latency"}, first_pulse, LAT);
  endtask

  task automatic ctrl_only(input bit do_clr, input bit do_load, input int val,
                           input bit do_errclr, input string tag);
    clr = do_clr; load = do_load; load_val = CNT_W'(val); err_clr = do_errclr;
    @(posedge virtualClk);
    @(negedge virtualClk);
    clr = 1'b0; load = 1'b0; err_clr = 1'b0;
    model_ctl(do_clr, do_load, val, do_errclr);
    check_output({tag, " pos"}, o_pos, m_pos);
    check_output({tag, " err"}, o_err, m_err);
  endtask

  // A held on the opposite level for len cycles, then restored.
  task automatic glitch_a(input int len, input string tag);
    logic [1:0] base, alt;
    int f1, b1, w1, f2, b2, w2, got_fw, got_bk, got_wr;
    int base_idx;
    base = seq[m_idx];
    alt = base ^ 2'b10;
    base_idx = m_idx;
    f1 = 0; b1 = 0; w1 = 0; f2 = 0; b2 = 0; w2 = 0;
    got_fw = 0; got_bk = 0; got_wr = 0;
    if (len >= 4) begin
      model_step(idx_of(alt), 1'b1, 1'b0, f1, b1, w1);
      model_step(base_idx, 1'b1, 1'b0, f2, b2, w2);
    end
    en = 1'b1;
    {a, b} = alt;
    for (int c = 1; c <= 20; c++) begin
      if (c == len + 1) {a, b} = base;
      @(posedge virtualClk);
      @(negedge virtualClk);
      if (o_forw) got_fw++;
      if (o_back) got_bk++;
      if (o_wrap) got_wr++;
    end
    check_output({tag, " forw"}, got_fw, f1 + f2);
    check_output({tag, " back"}, got_bk, b1 + b2);
    check_output({tag, " wrap"}, got_wr, w1 + w2);
    check_output({tag, " pos"}, o_pos, m_pos);
    check_output({tag, " err"}, o_err, m_err);
  endtask

  initial begin
    int r, kind, cr, ctl_at, nidx;
    rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1;
    clr = 1'b0; load = 1'b0; err_clr = 1'b0; load_val = '0;
    m_pos = 0; m_idx = 0; m_ud = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge virtualClk);
    check_output("reset pos", o_pos, 0);
    check_output("reset forw", o_forw, 0);
    check_output("reset back", o_back, 0);
    check_output("reset wrap", o_wrap, 0);
    check_output("reset ud", o_ud, 0);
    check_output("reset err", o_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge virtualClk);

    for (int i = 1; i <= 4; i++)
      apply_stimulus(i % 4, 1'b1, 0, 0, 0, 0, 0, 10, $sformatf("fwd%0d", i));

    ctrl_only(1'b1, 1'b0, 0, 1'b0, "clr");
    apply_stimulus(3, 1'b1, 0, 0, 0, 0, 0, 10, "back wrap");
    apply_stimulus(0, 1'b1, 0, 0, 0, 0, 0, 10, "fwd wrap");

    glitch_a(3, "glitch3");
    glitch_a(4, "glitch4");

    apply_stimulus(2, 1'b1, 0, 0, 0, 0, 0, 10, "illegal");
    apply_stimulus(3, 1'b1, 0, 0, 0, 0, 0, 10, "after illegal");
    ctrl_only(1'b0, 1'b0, 0, 1'b1, "errclr");

    apply_stimulus(0, 1'b1, 0, 1'b1, 'h1234, 0, LAT, 10, "load vs step");
    ctrl_only(1'b1, 1'b1, 'h5555, 1'b0, "clr vs load");
    apply_stimulus(2, 1'b1, 0, 0, 0, 1'b1, LAT, 10, "set vs errclr");
    ctrl_only(1'b0, 1'b0, 0, 1'b1, "errclr2");
    apply_stimulus(3, 1'b0, 0, 0, 0, 0, 0, 10, "disabled");
    apply_stimulus(0, 1'b1, 0, 0, 0, 0, 0, 10, "reenable");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      kind = (r < 40) ? 1 : (r < 80) ? 3 : (r < 90) ? 2 : 0;
      nidx = (m_idx + kind) % 4;
      cr = $urandom_range(0, 9);
      ctl_at = ($urandom_range(0, 1) == 0) ? LAT : $urandom_range(1, 9);
      apply_stimulus(nidx, $urandom_range(0, 4) != 0, cr == 0, cr == 1,
                     $urandom_range(0, POS_MOD - 1), cr == 2, ctl_at,
                     $urandom_range(10, 14), $sformatf("rnd%0d", i));
    end

    while (m_idx != 2)
      apply_stimulus((m_idx + 1) % 4, 1'b1, 0, 0, 0, 0, 0, 10, "walk");
    ctrl_only(1'b0, 1'b1, 7, 1'b0, "preload7");
    rst = 1'b1;
    #1;
    check_output("midrst pos", o_pos, 0);
    check_output("midrst forw", o_forw, 0);
    check_output("midrst ud", o_ud, 0);
    check_output("midrst err", o_err, 0);
    repeat (3) @(negedge virtualClk);
    rst = 1'b0;
    m_pos = 0; m_idx = 0; m_ud = 1'b0; m_err = 1'b0;
    apply_stimulus(2, 1'b1, 0, 0, 0, 0, 0, 12, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
